// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply and restoring divide, one bit per cycle.
// Fixed 34-edge latency from start to result, with flush and MTHI/MTLO support.
module mult_div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        wr_hi,
    input  logic        wr_lo,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t      state_r;
    logic [4:0]  count_r;
    logic [1:0]  op_r;
    logic [31:0] a_r;
    logic [31:0] b_r;
    logic [31:0] raw_a_r;
    logic [63:0] acc_r;
    logic        neg_q_r;
    logic        neg_r_r;
    logic        done_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;

    logic [32:0] mul_sum_s;
    logic [32:0] rem_sh_s;
    logic [31:0] rem_diff_s;
    logic [31:0] q_sh_s;
    logic [63:0] step_s;
    logic [63:0] prod_s;
    logic [31:0] quot_s;
    logic [31:0] rem_s;
    logic        sgn_a_s;
    logic        sgn_b_s;

    function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
        if (sgn) begin
            mag32 = 32'd0 - v;
        end else begin
            mag32 = v;
        end
    endfunction

    assign busy = (state_r != IDLE);
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

    // One iteration of the datapath plus the final sign correction terms.
    always_comb begin
        mul_sum_s  = {1'b0, acc_r[63:32]} + {1'b0, a_r};
        rem_sh_s   = acc_r[63:31];
        rem_diff_s = rem_sh_s[31:0] - b_r;
        q_sh_s     = {acc_r[30:0], 1'b0};
        step_s     = acc_r;
        if (op_r[1] == 1'b0) begin
            if (acc_r[0]) begin
                step_s = {mul_sum_s, acc_r[31:1]};
            end else begin
                step_s = {1'b0, acc_r[63:1]};
            end
        end else begin
            // Remainder stays below the divisor, so a failed trial always fits in 32 bits.
            if (rem_sh_s >= {1'b0, b_r}) begin
                step_s = {rem_diff_s, q_sh_s | 32'd1};
            end else begin
                step_s = {rem_sh_s[31:0], q_sh_s};
            end
        end
        prod_s  = neg_q_r ? (64'd0 - acc_r) : acc_r;
        quot_s  = neg_q_r ? (32'd0 - acc_r[31:0]) : acc_r[31:0];
        rem_s   = neg_r_r ? (32'd0 - acc_r[63:32]) : acc_r[63:32];
        sgn_a_s = ~op[0] & rs_data[31];
        sgn_b_s = ~op[0] & rt_data[31];
    end

    // Control FSM, iteration registers and architectural HI/LO.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            count_r <= 5'd0;
            op_r    <= 2'd0;
            a_r     <= 32'd0;
            b_r     <= 32'd0;
            raw_a_r <= 32'd0;
            acc_r   <= 64'd0;
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
            done_r  <= 1'b0;
            hi_r    <= 32'd0;
            lo_r    <= 32'd0;
        end else if (flush) begin
            state_r <= IDLE;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (wr_hi) hi_r <= rs_data;
                    if (wr_lo) lo_r <= rs_data;
                    if (start) begin
                        op_r    <= op;
                        a_r     <= mag32(rs_data, sgn_a_s);
                        b_r     <= mag32(rt_data, sgn_b_s);
                        raw_a_r <= rs_data;
                        neg_q_r <= sgn_a_s ^ sgn_b_s;
                        neg_r_r <= sgn_a_s;
                        acc_r   <= op[1] ? {32'd0, mag32(rs_data, sgn_a_s)}
                                         : {32'd0, mag32(rt_data, sgn_b_s)};
                        count_r <= 5'd0;
                        state_r <= RUN;
                    end
                end
                RUN: begin
                    acc_r   <= step_s;
                    count_r <= count_r + 5'd1;
                    if (count_r == 5'd31) state_r <= FIX;
                end
                FIX: begin
                    if (op_r[1] == 1'b0) begin
                        hi_r <= prod_s[63:32];
                        lo_r <= prod_s[31:0];
                    end else if (b_r == 32'd0) begin
                        hi_r <= raw_a_r;
                        lo_r <= 32'hFFFF_FFFF;
                    end else begin
                        hi_r <= rem_s;
                        lo_r <= quot_s;
                    end
                    done_r  <= 1'b1;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule
